// File: rtl/sram_arbiter_if.sv
// Signal bundle between two requesters, the arbiter and a single-port SRAM.
// slave = arbiter side; master = requesters plus SRAM model side.
interface sram_arbiter_if #(
    parameter int unsigned Width = 32,
    parameter int unsigned Aw    = 15
);
    localparam int unsigned Mw = Width / 8;

    logic [1:0]            req_valid_i;
    logic [1:0]            req_ready_o;
    logic [1:0]            req_write_i;
    logic [1:0][Aw-1:0]    req_addr_i;
    logic [1:0][Width-1:0] req_wdata_i;
    logic [1:0][Mw-1:0]    req_wmask_i;
    logic [1:0]            rsp_valid_o;
    logic [1:0]            rsp_ready_i;
    logic [Width-1:0]      rsp_rdata_o;
    logic                  sram_req_o;
    logic                  sram_write_o;
    logic [Aw-1:0]         sram_addr_o;
    logic [Width-1:0]      sram_wdata_o;
    logic [Mw-1:0]         sram_wmask_o;
    logic [Width-1:0]      sram_rdata_i;

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wmask_i,
        input  rsp_ready_i, sram_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o,
        output sram_req_o, sram_write_o, sram_addr_o, sram_wdata_o, sram_wmask_o
    );

    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wmask_i,
        output rsp_ready_i, sram_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o,
        input  sram_req_o, sram_write_o, sram_addr_o, sram_wdata_o, sram_wmask_o
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for a single-port SRAM with 1-cycle read latency and response hold.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (requester 0 wins).
module sram_arbiter #(
    parameter int unsigned Width = 32,
    parameter int unsigned Aw    = 15
) (
    input  logic           clk_i,
    input  logic           rst_i,
    sram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RESP, HOLD} state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic [Width-1:0] hold_q, hold_d;
    logic             rsp_fire;
    logic             issue_ok;
    logic [1:0]       req_elig;
    logic             grant_vld;
    logic             grant_idx;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;
`endif

    // A new access may issue only when the response path is free this cycle.
    always_comb begin
        rsp_fire  = (state_q != IDLE) && bus.rsp_ready_i[owner_q];
        issue_ok  = !rst_i && ((state_q == IDLE) || rsp_fire);
        req_elig  = bus.req_valid_i & {2{issue_ok}};
        grant_vld = |req_elig;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        grant_idx = req_elig[ptr_q] ? ptr_q : ~ptr_q;
`else
        grant_idx = ~req_elig[0];
`endif
    end

    // Grant handshake and SRAM strobe are combinational in the grant cycle.
    always_comb begin
        bus.req_ready_o  = '0;
        bus.sram_req_o   = 1'b0;
        bus.sram_write_o = 1'b0;
        bus.sram_addr_o  = '0;
        bus.sram_wdata_o = '0;
        bus.sram_wmask_o = '0;
        if (grant_vld) begin
            bus.req_ready_o[grant_idx] = 1'b1;
            bus.sram_req_o   = 1'b1;
            bus.sram_write_o = bus.req_write_i[grant_idx];
            bus.sram_addr_o  = bus.req_addr_i[grant_idx];
            bus.sram_wdata_o = bus.req_wdata_i[grant_idx];
            bus.sram_wmask_o = bus.req_wmask_i[grant_idx];
        end
    end

    always_comb begin
        bus.rsp_valid_o = '0;
        bus.rsp_rdata_o = '0;
        if (!rst_i) begin
            case (state_q)
                RESP: begin
                    bus.rsp_valid_o[owner_q] = 1'b1;
                    bus.rsp_rdata_o          = bus.sram_rdata_i;
                end
                HOLD: begin
                    bus.rsp_valid_o[owner_q] = 1'b1;
                    bus.rsp_rdata_o          = hold_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d = RESP;
                    owner_d = grant_idx;
                end
            end
            RESP, HOLD: begin
                if (rsp_fire) begin
                    if (grant_vld) begin
                        state_d = RESP;
                        owner_d = grant_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (state_q == RESP) begin
                    // SRAM data is only live for one cycle; keep it for the stalled owner.
                    state_d = HOLD;
                    hold_d  = bus.sram_rdata_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
        end
    end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // Pointer favours the requester that was not served last.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = ~grant_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule
